mem_lsu: RTL and testbench

// MEM-stage load/store unit between the EX/MEM and MEM/WB pipeline registers.

---
 rtl/mem_lsu.sv | 215 +++++++++++++++++++++
 tb/tb_mem_lsu.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit with a req/ack data-memory handshake and load formatting.
// Latency: a legal access takes 2+ cycles (IDLE issue, optional WAIT, DONE result); an illegal access is flagged in 1 cycle.
// Backpressure: stall_M is held high from issue until the memory acks or the wait budget expires; dmem_req stays up meanwhile.
//
// Ports:
//   clk, reset                      pipeline clock, synchronous active-high reset
//   memread_M, memwrite_M           load / store in MEM stage
//   funct3_M, aluresult_M           access size/sign and byte address
//   writeData_M                     store data (rs2)
//   readData_M, stall_M             formatted load result, pipeline freeze
//   exc_M, exc_cause_M              exception flag and cause (01 misaligned, 10 illegal, 11 timeout)
//   dmem_req/we/addr/wdata/be       data-memory request channel
//   dmem_ack, dmem_rdata            data-memory completion and read word
module mem_lsu #(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memread_M,
    input  logic        memwrite_M,
    input  logic [2:0]  funct3_M,
    input  logic [31:0] aluresult_M,
    input  logic [31:0] writeData_M,
    output logic [31:0] readData_M,
    output logic        stall_M,
    output logic        exc_M,
    output logic [1:0]  exc_cause_M,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata
);

    localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  off_q, off_d;
    logic [2:0]  f3_q, f3_d;
    logic        we_q, we_d;
    logic        tmo_q, tmo_d;

    // Access decode on the live EX/MEM fields.
    logic access, both_ops, f3_ok, misal, legal;

    always_comb begin
        access   = memread_M | memwrite_M;
        both_ops = memread_M & memwrite_M;
        case (funct3_M)
            3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
            3'b100, 3'b101:         f3_ok = ~memwrite_M;  // unsigned sizes are load-only
            default:                f3_ok = 1'b0;
        endcase
        case (funct3_M)
            3'b001, 3'b101: misal = aluresult_M[0];
            3'b010:         misal = |aluresult_M[1:0];
            default:        misal = 1'b0;
        endcase
        legal = access & ~both_ops & f3_ok & ~misal;
    end

    // Store lane steering: data replicated across the word, enables select the lanes.
    logic [3:0]  be_st;
    logic [31:0] wdata_st;

    always_comb begin
        case (funct3_M[1:0])
            2'b00: begin
                be_st    = 4'b0001 << aluresult_M[1:0];
                wdata_st = {4{writeData_M[7:0]}};
            end
            2'b01: begin
                be_st    = 4'b0011 << aluresult_M[1:0];
                wdata_st = {2{writeData_M[15:0]}};
            end
            default: begin
                be_st    = 4'b1111;
                wdata_st = writeData_M;
            end
        endcase
    end

    // Load formatting from the captured word and the latched offset/size.
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_fmt;

    always_comb begin
        case (off_q)
            2'd0:    ld_byte = rdata_q[7:0];
            2'd1:    ld_byte = rdata_q[15:8];
            2'd2:    ld_byte = rdata_q[23:16];
            default: ld_byte = rdata_q[31:24];
        endcase
        ld_half = off_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        case (f3_q)
            3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
            3'b010:  ld_fmt = rdata_q;
            3'b100:  ld_fmt = {24'd0, ld_byte};
            3'b101:  ld_fmt = {16'd0, ld_half};
            default: ld_fmt = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            rdata_q <= 32'd0;
            off_q   <= 2'd0;
            f3_q    <= 3'd0;
            we_q    <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            off_q   <= off_d;
            f3_q    <= f3_d;
            we_q    <= we_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        off_d       = off_q;
        f3_d        = f3_q;
        we_d        = we_q;
        tmo_d       = tmo_q;
        dmem_req    = 1'b0;
        stall_M     = 1'b0;
        exc_M       = 1'b0;
        exc_cause_M = 2'b00;
        readData_M  = 32'd0;

        case (state_q)
            S_IDLE: begin
                if (access && !legal) begin
                    // Bad size or conflicting ops outrank misalignment.
                    exc_M       = 1'b1;
                    exc_cause_M = (both_ops || !f3_ok) ? 2'b10 : 2'b01;
                end else if (legal) begin
                    dmem_req = 1'b1;
                    stall_M  = 1'b1;
                    off_d    = aluresult_M[1:0];
                    f3_d     = funct3_M;
                    we_d     = memwrite_M;
                    tmo_d    = 1'b0;
                    if (dmem_ack) begin
                        rdata_d = dmem_rdata;
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = 8'd1;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // The stage is frozen, so the request fields come straight from EX/MEM.
                dmem_req = 1'b1;
                stall_M  = 1'b1;
                if (dmem_ack) begin
                    rdata_d = dmem_rdata;
                    state_d = S_DONE;
                end else if (cnt_q == MAX_W) begin
                    tmo_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DONE: begin
                cnt_d   = 8'd0;
                state_d = S_IDLE;
                if (tmo_q) begin
                    exc_M       = 1'b1;
                    exc_cause_M = 2'b11;
                end else if (!we_q) begin
                    readData_M = ld_fmt;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (reset) begin
            dmem_req    = 1'b0;
            stall_M     = 1'b0;
            exc_M       = 1'b0;
            exc_cause_M = 2'b00;
            readData_M  = 32'd0;
        end
    end

    assign dmem_we    = dmem_req & memwrite_M;
    assign dmem_addr  = {aluresult_M[31:2], 2'b00};
    assign dmem_be    = memwrite_M ? be_st : 4'b1111;
    assign dmem_wdata = wdata_st;

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed and randomised load/store sequences against mem_lsu with a result scoreboard.
// Latency: each access is driven until stall_M drops; the result is then popped from the scoreboard and compared.
// Backpressure: the bench plays the memory, asserting dmem_ack after a chosen number of WAIT cycles or never.
module tb_mem_lsu;

    localparam int MAXW = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        memread_M, memwrite_M;
    logic [2:0]  funct3_M;
    logic [31:0] aluresult_M, writeData_M;
    logic [31:0] readData_M;
    logic        stall_M, exc_M;
    logic [1:0]  exc_cause_M;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    int n_cmp = 0;
    int n_mis = 0;

    typedef struct {
        logic [31:0] rd;
        logic        exc;
        logic [1:0]  cause;
        int          stall;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    mem_lsu #(.MAX_WAIT(MAXW)) dut (
        .clk(clk), .reset(reset),
        .memread_M(memread_M), .memwrite_M(memwrite_M),
        .funct3_M(funct3_M), .aluresult_M(aluresult_M), .writeData_M(writeData_M),
        .readData_M(readData_M), .stall_M(stall_M),
        .exc_M(exc_M), .exc_cause_M(exc_cause_M),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference load formatter written from the size/sign definitions.
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] w);
        logic [31:0] sh;
        sh = w >> (8 * off);
        case (f3)
            3'b000:  return (sh[7] ? 32'hFFFF_FF00 : 32'h0) | (sh & 32'hFF);
            3'b001:  return (sh[15] ? 32'hFFFF_0000 : 32'h0) | (sh & 32'hFFFF);
            3'b100:  return sh & 32'hFF;
            3'b101:  return sh & 32'hFFFF;
            default: return w;
        endcase
    endfunction

    // ack_at: index of the stalled cycle (0 = issue cycle) in which dmem_ack is raised; -1 = never.
    task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int ack_at, input logic [31:0] rdata,
                          input logic [31:0] exp_rd, input logic [1:0] exp_cause, input int exp_stall,
                          input logic [3:0] exp_be, input logic [31:0] exp_wdata);
        int   cyc;
        exp_t e;
        sb.push_back('{exp_rd, exp_cause != 2'b00, exp_cause, exp_stall});
        @(negedge clk);
        memread_M   = rd;
        memwrite_M  = wr;
        funct3_M    = f3;
        aluresult_M = a;
        writeData_M = wd;
        dmem_rdata  = rdata;
        dmem_ack    = (ack_at == 0);
        #1;
        if (exp_stall > 0) begin
            chk("issue_req", dmem_req, 1'b1);
            chk("issue_we", dmem_we, wr);
            chk("issue_be", dmem_be, exp_be);
            chk("issue_addr", dmem_addr, {a[31:2], 2'b00});
            if (wr) chk("issue_wdata", dmem_wdata, exp_wdata);
        end else begin
            chk("illegal_no_req", dmem_req, 1'b0);
        end
        cyc = 0;
        while (stall_M === 1'b1 && cyc <= MAXW + 4) begin
            cyc++;
            @(negedge clk);
            dmem_ack = (cyc == ack_at);
            #1;
            if (stall_M === 1'b1) chk("wait_req", dmem_req, 1'b1);
        end
        e = sb.pop_front();
        chk("stall_cycles", cyc, e.stall);
        chk("result_rd", readData_M, e.rd);
        chk("result_exc", exc_M, e.exc);
        chk("result_cause", exc_cause_M, e.cause);
        chk("result_req_low", dmem_req, 1'b0);
        memread_M  = 1'b0;
        memwrite_M = 1'b0;
        dmem_ack   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with a legal load presented: outputs must stay quiet.
        reset       = 1'b1;
        memread_M   = 1'b1;
        memwrite_M  = 1'b0;
        funct3_M    = 3'b010;
        aluresult_M = 32'h100;
        writeData_M = 32'h0;
        dmem_ack    = 1'b0;
        dmem_rdata  = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req", dmem_req, 1'b0);
        chk("rst_stall", stall_M, 1'b0);
        chk("rst_exc", exc_M, 1'b0);
        chk("rst_rd", readData_M, 32'h0);
        @(negedge clk);
        reset     = 1'b0;
        memread_M = 1'b0;
        #1;
        chk("idle_req", dmem_req, 1'b0);
        chk("idle_stall", stall_M, 1'b0);

        // Directed accesses.
        access(1, 0, 3'b010, 32'h100, 0, 0,  32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 1, 4'b1111, 0);
        access(1, 0, 3'b000, 32'h103, 0, 3,  32'h80123456, 32'hFFFFFF80, 2'b00, 4, 4'b1111, 0);
        access(1, 0, 3'b100, 32'h103, 0, 3,  32'h80123456, 32'h00000080, 2'b00, 4, 4'b1111, 0);
        access(0, 1, 3'b001, 32'h102, 32'h0000ABCD, 0, 32'h55555555, 32'h0, 2'b00, 1, 4'b1100, 32'hABCDABCD);
        access(0, 1, 3'b000, 32'h101, 32'h12345678, 2, 32'h0, 32'h0, 2'b00, 3, 4'b0010, 32'h78787878);
        access(0, 1, 3'b010, 32'h104, 32'hCAFEF00D, 1, 32'h0, 32'h0, 2'b00, 2, 4'b1111, 32'hCAFEF00D);
        access(1, 0, 3'b001, 32'h102, 0, 0,  32'h80010000, 32'hFFFF8001, 2'b00, 1, 4'b1111, 0);
        access(1, 0, 3'b101, 32'h102, 0, 1,  32'h80010000, 32'h00008001, 2'b00, 2, 4'b1111, 0);
        // Illegal accesses.
        access(1, 0, 3'b010, 32'h101, 0, -1, 32'h0, 32'h0, 2'b01, 0, 4'b1111, 0);
        access(1, 0, 3'b011, 32'h100, 0, -1, 32'h0, 32'h0, 2'b10, 0, 4'b1111, 0);
        access(1, 1, 3'b010, 32'h100, 0, -1, 32'h0, 32'h0, 2'b10, 0, 4'b1111, 0);
        access(1, 1, 3'b010, 32'h101, 0, -1, 32'h0, 32'h0, 2'b10, 0, 4'b1111, 0);
        access(0, 1, 3'b100, 32'h100, 0, -1, 32'h0, 32'h0, 2'b10, 0, 4'b1111, 0);
        access(0, 1, 3'b001, 32'h103, 0, -1, 32'h0, 32'h0, 2'b01, 0, 4'b1111, 0);
        // Timeout: no ack ever.
        access(1, 0, 3'b001, 32'h200, 0, -1, 32'h12345678, 32'h0, 2'b11, MAXW + 1, 4'b1111, 0);
        // Ack one cycle before the budget expires still completes normally.
        access(1, 0, 3'b010, 32'h204, 0, MAXW, 32'h0BADF00D, 32'h0BADF00D, 2'b00, MAXW + 1, 4'b1111, 0);

        // Stray ack with no request.
        @(negedge clk);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hFFFFFFFF;
        #1;
        chk("stray_idle_req", dmem_req, 1'b0);
        chk("stray_idle_stall", stall_M, 1'b0);
        @(negedge clk);
        dmem_ack = 1'b0;
        #1;
        chk("stray_idle_rd", readData_M, 32'h0);

        // Reset in the middle of WAIT.
        @(negedge clk);
        memread_M   = 1'b1;
        funct3_M    = 3'b010;
        aluresult_M = 32'h300;
        repeat (3) @(negedge clk);
        #1;
        chk("midwait_stall", stall_M, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midwait_rst_req", dmem_req, 1'b0);
        chk("midwait_rst_stall", stall_M, 1'b0);
        @(negedge clk);
        reset     = 1'b0;
        memread_M = 1'b0;
        #1;
        chk("post_rst_req", dmem_req, 1'b0);
        chk("post_rst_stall", stall_M, 1'b0);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hA5A5A5A5;
        @(negedge clk);
        #1;
        chk("post_rst_stray_rd", readData_M, 32'h0);
        chk("post_rst_stray_exc", exc_M, 1'b0);
        chk("post_rst_stray_stall", stall_M, 1'b0);
        dmem_ack = 1'b0;
        access(1, 0, 3'b010, 32'h300, 0, 0, 32'h13579BDF, 32'h13579BDF, 2'b00, 1, 4'b1111, 0);

        // Randomised legal loads with a reference formatter.
        for (int i = 0; i < 24; i++) begin
            logic [2:0]  f3;
            logic [31:0] a, w;
            int          sel, dly;
            sel = int'($urandom_range(0, 4));
            case (sel)
                0: f3 = 3'b000;
                1: f3 = 3'b001;
                2: f3 = 3'b010;
                3: f3 = 3'b100;
                default: f3 = 3'b101;
            endcase
            a = $urandom & 32'hFFFF_FFFC;
            if (f3 == 3'b000 || f3 == 3'b100) a[1:0] = 2'($urandom_range(0, 3));
            if (f3 == 3'b001 || f3 == 3'b101) a[1] = 1'($urandom_range(0, 1));
            w   = $urandom;
            dly = int'($urandom_range(0, 4));
            access(1, 0, f3, a, 0, dly, w, ref_load(f3, a[1:0], w), 2'b00, dly + 1, 4'b1111, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
